// File: rtl/vga_frame_decoder.sv
// vga_frame_decoder: recovers paddle and ball positions from a 1-bit-per-colour
// VGA pixel stream while checking the sync timing.
//   clk, rst (async, active low)     pixel clock, one pixel per cycle
//   hsync, vsync                     active-low syncs
//   red, green, blue                 pixel is lit when any is high
//   locked                           timing verified for at least one frame
//   frame_valid                      1-cycle pulse after positions are published
//   timing_error                     1-cycle pulse on a sync timing violation
//   paddle_1_pos, paddle_2_pos       top row of each paddle
//   ball_pos_x, ball_pos_y           top-left corner of the ball
module vga_frame_decoder #(
    parameter int unsigned H_ACTIVE            = 640,
    parameter int unsigned H_FP                = 16,
    parameter int unsigned H_SYNC              = 96,
    parameter int unsigned H_BP                = 48,
    parameter int unsigned V_ACTIVE            = 480,
    parameter int unsigned V_FP                = 10,
    parameter int unsigned V_SYNC              = 2,
    parameter int unsigned V_BP                = 33,
    parameter int unsigned PADDLE_1_X          = 40,
    parameter int unsigned PADDLE_2_X          = 585,
    parameter int unsigned PADDLE_WIDTH        = 15,
    parameter int unsigned HEIGHT_COUNTER_SIZE = $clog2(V_ACTIVE + 1),
    parameter int unsigned WIDTH_COUNTER_SIZE  = $clog2(H_ACTIVE + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           hsync,
    input  logic                           vsync,
    input  logic                           red,
    input  logic                           green,
    input  logic                           blue,
    output logic                           locked,
    output logic                           frame_valid,
    output logic                           timing_error,
    output logic [HEIGHT_COUNTER_SIZE:0]   paddle_1_pos,
    output logic [HEIGHT_COUNTER_SIZE:0]   paddle_2_pos,
    output logic [WIDTH_COUNTER_SIZE:0]    ball_pos_x,
    output logic [HEIGHT_COUNTER_SIZE:0]   ball_pos_y
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL + 1);
    localparam int unsigned VW      = $clog2(V_TOTAL + 1);
    localparam int unsigned XW      = WIDTH_COUNTER_SIZE + 1;
    localparam int unsigned YW      = HEIGHT_COUNTER_SIZE + 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_OVER = HW'(H_TOTAL);
    localparam logic [HW-1:0] H_X0   = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_X1   = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_OVER = VW'(V_TOTAL);
    localparam logic [VW-1:0] V_Y0   = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_Y1   = VW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [XW-1:0] P1_LO  = XW'(PADDLE_1_X);
    localparam logic [XW-1:0] P1_HI  = XW'(PADDLE_1_X + PADDLE_WIDTH);
    localparam logic [XW-1:0] P2_LO  = XW'(PADDLE_2_X);
    localparam logic [XW-1:0] P2_HI  = XW'(PADDLE_2_X + PADDLE_WIDTH);

    typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

    state_t          state;
    logic            hs_q;
    logic            vs_q;
    logic            lit_q;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic [YW-1:0]   p1_min;
    logic [YW-1:0]   p2_min;
    logic [XW-1:0]   bx_min;
    logic [YW-1:0]   by_min;
    logic            publish_q;

    logic            hs_fall_c;
    logic            vs_fall_c;
    logic [XW-1:0]   x_c;
    logic [YW-1:0]   y_c;
    logic            pix_c;
    logic            in_paddle_c;
    logic            h_bad_c;
    logic            v_bad_c;
    logic            viol_c;
    logic            publish_c;
    logic            lock_next_c;

    // Edges are detected as the falling sync enters its input register, so the
    // counters restart in the same cycle the registered sync shows the edge.
    always_comb begin
        hs_fall_c   = hs_q & ~hsync;
        vs_fall_c   = vs_q & ~vsync;
        x_c         = XW'(h_cnt - H_X0);
        y_c         = YW'(v_cnt - V_Y0);
        pix_c       = lit_q && (h_cnt >= H_X0) && (h_cnt < H_X1)
                            && (v_cnt >= V_Y0) && (v_cnt < V_Y1);
        in_paddle_c = ((x_c >= P1_LO) && (x_c < P1_HI))
                   || ((x_c >= P2_LO) && (x_c < P2_HI));
        h_bad_c     = (hs_fall_c && (h_cnt != H_LAST)) || (h_cnt >= H_OVER);
        v_bad_c     = (vs_fall_c && (v_cnt != V_LAST)) || (v_cnt >= V_OVER);
        viol_c      = (state != S_SEARCH) && (h_bad_c || v_bad_c);
        publish_c   = (state != S_SEARCH) && vs_fall_c && !viol_c;
        lock_next_c = (state == S_LOCKED && !viol_c) || publish_c;
    end

    // Input stage, counters, lock FSM, trackers and published outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_SEARCH;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            lit_q        <= 1'b0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            p1_min       <= '1;
            p2_min       <= '1;
            bx_min       <= '1;
            by_min       <= '1;
            publish_q    <= 1'b0;
            locked       <= 1'b0;
            frame_valid  <= 1'b0;
            timing_error <= 1'b0;
            paddle_1_pos <= '1;
            paddle_2_pos <= '1;
            ball_pos_x   <= '1;
            ball_pos_y   <= '1;
        end else begin
            hs_q  <= hsync;
            vs_q  <= vsync;
            lit_q <= red | green | blue;

            // Saturating counters: an absent sync cannot wrap back into range.
            if (hs_fall_c)
                h_cnt <= '0;
            else if (h_cnt != '1)
                h_cnt <= h_cnt + HW'(1);

            if (vs_fall_c)
                v_cnt <= '0;
            else if (hs_fall_c && (v_cnt != '1))
                v_cnt <= v_cnt + VW'(1);

            unique case (state)
                S_SEARCH:  if (vs_fall_c) state <= S_MEASURE;
                S_MEASURE: begin
                    if (viol_c)         state <= S_SEARCH;
                    else if (vs_fall_c) state <= S_LOCKED;
                end
                S_LOCKED:  if (viol_c) state <= S_SEARCH;
                default:   state <= S_SEARCH;
            endcase

            locked       <= lock_next_c;
            timing_error <= viol_c;
            publish_q    <= publish_c;
            frame_valid  <= publish_q;

            // Trackers are read for publishing before the frame restart clears them.
            if (publish_c) begin
                paddle_1_pos <= p1_min;
                paddle_2_pos <= p2_min;
                ball_pos_x   <= bx_min;
                ball_pos_y   <= by_min;
            end

            if (vs_fall_c) begin
                p1_min <= '1;
                p2_min <= '1;
                bx_min <= '1;
                by_min <= '1;
            end else if (pix_c) begin
                if ((x_c == P1_LO) && (y_c < p1_min)) p1_min <= y_c;
                if ((x_c == P2_LO) && (y_c < p2_min)) p2_min <= y_c;
                if (!in_paddle_c) begin
                    if (x_c < bx_min) bx_min <= x_c;
                    if (y_c < by_min) by_min <= y_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_decoder.sv
// tb_vga_frame_decoder: directed frames on a reduced 16x12 raster
// (H_TOTAL 24, V_TOTAL 17) with hand-computed positions per scene.
module tb_vga_frame_decoder;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 12;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int P1X      = 1;
    localparam int P2X      = 12;
    localparam int PW       = 3;
    localparam int PH       = 4;
    localparam int H_TOTAL  = 24;
    localparam int V_TOTAL  = 17;
    localparam int H_OFF    = 6;
    localparam int V_OFF    = 4;
    localparam int Y_ONES   = 31;
    localparam int X_ONES   = 63;

    typedef struct {
        int         p1y;
        int         p2y;
        int         bx;
        int         by;
        bit         dark;
        bit         noise;
        logic [2:0] ball_rgb;
    } scene_t;

    bit         clk = 1'b0;
    logic       rst;
    logic       hsync;
    logic       vsync;
    logic       red;
    logic       green;
    logic       blue;
    logic       locked;
    logic       frame_valid;
    logic       timing_error;
    logic [4:0] paddle_1_pos;
    logic [4:0] paddle_2_pos;
    logic [5:0] ball_pos_x;
    logic [4:0] ball_pos_y;

    int n_cmp = 0;
    int n_err = 0;
    int fv_cnt = 0;
    int te_cnt = 0;

    scene_t sc_a, sc_dark, sc_c, sc_d;

    vga_frame_decoder #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .PADDLE_1_X(P1X), .PADDLE_2_X(P2X), .PADDLE_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .locked(locked), .frame_valid(frame_valid), .timing_error(timing_error),
        .paddle_1_pos(paddle_1_pos), .paddle_2_pos(paddle_2_pos),
        .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y)
    );

    always #5 clk = ~clk;

    // Pulse-cycle counters; a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (timing_error === 1'b1) te_cnt <= te_cnt + 1;
        if (frame_valid === 1'b1)  fv_cnt <= fv_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] pix(input scene_t s, input int x, input int y);
        if (x < 0 || x >= H_ACTIVE || y < 0 || y >= V_ACTIVE)
            return s.noise ? 3'b100 : 3'b000;
        if (s.dark) return 3'b000;
        if (x >= P1X && x < P1X + PW && y >= s.p1y && y < s.p1y + PH) return 3'b001;
        if (x >= P2X && x < P2X + PW && y >= s.p2y && y < s.p2y + PH) return 3'b001;
        if (x >= s.bx && x < s.bx + 3 && y >= s.by && y < s.by + 2) return s.ball_rgb;
        return 3'b000;
    endfunction

    // Drives lines first..last of a frame; short_line gets one clock fewer.
    task automatic send_lines(input scene_t s, input int first, input int last,
                              input int short_line, input bit vs_on);
        int len;
        for (int l = first; l <= last; l++) begin
            len = (l == short_line) ? H_TOTAL - 1 : H_TOTAL;
            for (int h = 0; h < len; h++) begin
                hsync = (h < H_SYNC) ? 1'b0 : 1'b1;
                vsync = (vs_on && l < V_SYNC) ? 1'b0 : 1'b1;
                {red, green, blue} = pix(s, h - H_OFF, l - V_OFF);
                @(negedge clk);
            end
        end
    endtask

    task automatic frame(input scene_t s, input int short_line, input bit vs_on);
        send_lines(s, 0, V_TOTAL - 1, short_line, vs_on);
        #1;
    endtask

    task automatic check_pos(input string tag, input int p1, input int p2, input int bx, input int by);
        check_eq({tag, "_p1"}, 32'(paddle_1_pos), p1);
        check_eq({tag, "_p2"}, 32'(paddle_2_pos), p2);
        check_eq({tag, "_bx"}, 32'(ball_pos_x), bx);
        check_eq({tag, "_by"}, 32'(ball_pos_y), by);
    endtask

    initial begin
        sc_a    = '{p1y: 3, p2y: 5, bx: 7, by: 6, dark: 1'b0, noise: 1'b0, ball_rgb: 3'b010};
        sc_dark = '{p1y: 0, p2y: 0, bx: 0, by: 0, dark: 1'b1, noise: 1'b1, ball_rgb: 3'b000};
        sc_c    = '{p1y: 3, p2y: 5, bx: 2, by: 9, dark: 1'b0, noise: 1'b0, ball_rgb: 3'b100};
        sc_d    = '{p1y: 8, p2y: 0, bx: 5, by: 0, dark: 1'b0, noise: 1'b0, ball_rgb: 3'b001};

        rst = 1'b0; hsync = 1'b1; vsync = 1'b1; {red, green, blue} = 3'b000;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_locked", 32'(locked), 0);
        check_eq("rst_fv", 32'(frame_valid), 0);
        check_eq("rst_te", 32'(timing_error), 0);
        check_pos("rst", Y_ONES, Y_ONES, X_ONES, Y_ONES);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Acquisition: locks at the second vsync edge, publishing frame 1.
        frame(sc_a, -1, 1'b1);
        check_eq("f1_locked", 32'(locked), 0);
        frame(sc_a, -1, 1'b1);
        check_eq("f2_locked", 32'(locked), 1);
        check_pos("f2", 3, 5, 7, 6);
        check_eq("f2_fv_cnt", fv_cnt, 1);
        check_eq("f2_te_cnt", te_cnt, 0);

        // Dark frame with lit blanking: nothing qualifies.
        frame(sc_dark, -1, 1'b1);
        frame(sc_a, -1, 1'b1);
        check_pos("dark", Y_ONES, Y_ONES, X_ONES, Y_ONES);
        check_eq("dark_fv_cnt", fv_cnt, 3);

        // Ball overlapping paddle 1 columns, then ball and paddle on row 0.
        frame(sc_c, -1, 1'b1);
        frame(sc_d, -1, 1'b1);
        check_pos("overlap", 3, 5, 4, 9);
        frame(sc_a, -1, 1'b1);
        check_pos("edge", 8, 0, 5, 0);

        // Short line while locked: error, positions held, relock after two frames.
        frame(sc_a, 5, 1'b1);
        check_eq("short_te_cnt", te_cnt, 1);
        check_eq("short_locked", 32'(locked), 0);
        check_pos("short_hold", 3, 5, 7, 6);
        check_eq("short_fv_cnt", fv_cnt, 7);
        frame(sc_c, -1, 1'b1);
        check_eq("relock1_locked", 32'(locked), 0);
        check_eq("relock1_bx", 32'(ball_pos_x), 7);
        check_eq("relock1_fv_cnt", fv_cnt, 7);
        frame(sc_c, -1, 1'b1);
        check_eq("relock2_locked", 32'(locked), 1);
        check_pos("relock2", 3, 5, 4, 9);
        check_eq("relock2_fv_cnt", fv_cnt, 8);

        // Reset mid-frame while locked.
        send_lines(sc_d, 0, 7, -1, 1'b1);
        rst = 1'b0;
        #1;
        check_eq("midrst_locked", 32'(locked), 0);
        check_pos("midrst", Y_ONES, Y_ONES, X_ONES, Y_ONES);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send_lines(sc_d, 8, V_TOTAL - 1, -1, 1'b1);
        #1;
        check_eq("postrst_locked", 32'(locked), 0);
        check_eq("postrst_bx", 32'(ball_pos_x), X_ONES);
        frame(sc_d, -1, 1'b1);
        check_eq("postrst_f2_locked", 32'(locked), 0);
        frame(sc_a, -1, 1'b1);
        check_eq("postrst_f3_locked", 32'(locked), 1);
        check_pos("postrst_f3", 8, 0, 5, 0);
        check_eq("postrst_fv_cnt", fv_cnt, 10);

        // Missing vsync: v_cnt overruns, error, no publish.
        frame(sc_a, -1, 1'b0);
        check_eq("novs_te_cnt", te_cnt, 2);
        check_eq("novs_locked", 32'(locked), 0);
        check_eq("novs_fv_cnt", fv_cnt, 10);
        check_pos("novs_hold", 8, 0, 5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_frame_decoder.md
VGA_FRAME_DECODER -- requirements
Module: vga_frame_decoder

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal porch and sync widths in clocks; H_TOTAL = sum of all four = 800.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines; V_TOTAL = 525.
REQ-004 SHALL have parameters PADDLE_1_X 40, PADDLE_2_X 585, PADDLE_WIDTH 15: paddle column origins and width in pixels.
REQ-005 SHALL have parameters HEIGHT_COUNTER_SIZE $clog2(V_ACTIVE+1) and WIDTH_COUNTER_SIZE $clog2(H_ACTIVE+1).
REQ-006 Port: clk, input, 1, pixel clock, one pixel per cycle.
REQ-007 Port: rst, input, 1, asynchronous active-low reset.
REQ-008 Ports: hsync, vsync, input, 1 each, active-low sync.
REQ-009 Ports: red, green, blue, input, 1 each; a pixel is lit when any of the three is 1.
REQ-010 Port: locked, output, 1, high while timing is verified.
REQ-011 Port: frame_valid, output, 1, single-cycle pulse when new positions are published.
REQ-012 Port: timing_error, output, 1, single-cycle pulse on a timing violation.
REQ-013 Ports: paddle_1_pos, paddle_2_pos, output, HEIGHT_COUNTER_SIZE+1 each, decoded paddle top row.
REQ-014 Ports: ball_pos_x, output, WIDTH_COUNTER_SIZE+1; ball_pos_y, output, HEIGHT_COUNTER_SIZE+1; decoded ball top-left corner.

Function
REQ-015 All inputs SHALL pass through one register stage; all timing below refers to the registered inputs.
REQ-016 An hsync edge is a registered 1->0 transition; h_cnt SHALL be 0 on the edge cycle and increment by 1 on every subsequent cycle.
REQ-017 A vsync edge is a registered 1->0 transition; v_cnt SHALL be 0 on the line of the vsync edge and increment on each hsync edge.
REQ-018 Active x = h_cnt - (H_SYNC+H_BP), active y = v_cnt - (V_SYNC+V_BP); a pixel is active only when 0 <= x < H_ACTIVE and 0 <= y < V_ACTIVE.
REQ-019 FSM states: SEARCH, MEASURE, LOCKED.
- SEARCH: on vsync edge -> MEASURE.
- MEASURE: after one full frame with no violation, at the next vsync edge -> LOCKED.
- LOCKED: remains until a violation.
REQ-020 A violation occurs in MEASURE or LOCKED when:
- an hsync edge arrives with h_cnt != H_TOTAL-1, or h_cnt reaches H_TOTAL without an edge; or
- a vsync edge arrives with v_cnt != V_TOTAL-1, or v_cnt reaches V_TOTAL without an edge.
REQ-021 On a violation: pulse timing_error for 1 cycle, go to SEARCH, deassert locked in the same cycle, hold the position outputs.
REQ-022 Per frame the block SHALL track:
- p1_min: minimum y with a lit pixel at x == PADDLE_1_X.
- p2_min: minimum y with a lit pixel at x == PADDLE_2_X.
- bx_min, by_min: minimum x and minimum y over lit active pixels outside [PADDLE_1_X, PADDLE_1_X+PADDLE_WIDTH) and [PADDLE_2_X, PADDLE_2_X+PADDLE_WIDTH).
REQ-023 Trackers SHALL initialise to all-ones on every vsync edge; if no qualifying pixel is seen, the published value SHALL be all-ones.
REQ-024 On each vsync edge in LOCKED (including the MEASURE->LOCKED edge), the previous frame's trackers SHALL be copied to the outputs and frame_valid pulsed 1 cycle later.
REQ-025 A vsync edge coinciding with a violation SHALL count as a violation; nothing is published for that frame.
REQ-026 Counters SHALL saturate at all-ones rather than wrap while in SEARCH.

Reset
REQ-027 While rst=0: state SEARCH; locked, frame_valid and timing_error 0; all position outputs and trackers all-ones; counters 0.
REQ-028 Deassertion SHALL take effect on the first clk edge after rst=1; no frame in progress at reset release is published.

Verification
REQ-029 Nominal 640x480 stream, paddles at y=190, ball at (308,228) -> locked after the 2nd vsync edge; on the 3rd frame paddle_1_pos=190, paddle_2_pos=190, ball_pos_x=308, ball_pos_y=228, with a frame_valid pulse.
REQ-030 One line of 799 clocks in a locked stream -> timing_error pulse, locked=0, positions held; relocks after 2 clean frames.
REQ-031 Frame with all pixels dark -> all four position outputs all-ones, frame_valid still pulses.
REQ-032 Ball at x=45 (overlapping the paddle 1 columns) and at x=70 -> ball_pos_x excludes columns 40..54; reports 55 and 70 respectively.
REQ-033 rst asserted mid-frame while locked -> outputs immediately return to reset values; after release, locked only after SEARCH->MEASURE->LOCKED.
REQ-034 vsync missing for 526 lines -> timing_error at v_cnt=525, state SEARCH.
